// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the instruction fetch stage and its queue.
package instruction_fetch_pkg;

    localparam int          IF_WORDSIZE = 64;
    localparam int          IF_INSTR_W  = 32;
    localparam int          IF_DEPTH    = 2;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/instruction_fetch_queue.sv
// In-order fetch queue: entries are allocated at request time, filled when memory
// answers, and read out in allocation order.
module fetch_queue
    import instruction_fetch_pkg::*;
#(
    parameter int WORDSIZE = IF_WORDSIZE,
    parameter int IW       = IF_INSTR_W,
    parameter int DEPTH    = IF_DEPTH,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  logic [WORDSIZE-1:0] push_pc_i,
    input  logic                fill_i,
    input  logic [IW-1:0]       fill_data_i,
    input  logic                pop_i,
    input  logic                flush_i,
    output logic [CW-1:0]       count_o,
    output logic [CW-1:0]       pending_o,
    output logic                head_valid_o,
    output logic [IW-1:0]       head_instr_o,
    output logic [WORDSIZE-1:0] head_pc_o
);

    logic [WORDSIZE-1:0] pc_q    [DEPTH];
    logic [IW-1:0]       instr_q [DEPTH];
    logic [DEPTH-1:0]    filled_q;
    logic [PW-1:0]       alloc_q, fill_q, rd_q;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       n_filled;

    // Payload needs no reset: it is only visible through a set filled bit.
    always_ff @(posedge clk) begin
        if (push_i) pc_q[alloc_q]   <= push_pc_i;
        if (fill_i) instr_q[fill_q] <= fill_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filled_q <= '0;
            alloc_q  <= '0;
            fill_q   <= '0;
            rd_q     <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            filled_q <= '0;
            count_q  <= '0;
            alloc_q  <= rd_q;
            fill_q   <= rd_q;
        end else begin
            if (push_i) begin
                filled_q[alloc_q] <= 1'b0;
                alloc_q           <= alloc_q + PW'(1);
            end
            if (fill_i) begin
                filled_q[fill_q] <= 1'b1;
                fill_q           <= fill_q + PW'(1);
            end
            if (pop_i) begin
                filled_q[rd_q] <= 1'b0;
                rd_q           <= rd_q + PW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_comb begin
        n_filled = '0;
        for (int i = 0; i < DEPTH; i++) n_filled = n_filled + CW'(filled_q[i]);
    end

    // Allocated entries still waiting for their memory response.
    assign pending_o    = count_q - n_filled;
    assign count_o      = count_q;
    assign head_valid_o = filled_q[rd_q] & (count_q != '0);
    assign head_instr_o = head_valid_o ? instr_q[rd_q] : '0;
    assign head_pc_o    = head_valid_o ? pc_q[rd_q]    : '0;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues in-order imem reads for the PC stream, queues tagged
// instructions for decode, and discards in-flight responses after a flush.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int WORDSIZE = IF_WORDSIZE,
    parameter int INSTR_W  = IF_INSTR_W,
    parameter int DEPTH    = IF_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WORDSIZE-1:0] pc_addr,
    input  logic                pc_valid,
    output logic                pc_ready,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [WORDSIZE-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    input  logic                flush,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [INSTR_W-1:0]  id_instr,
    output logic [WORDSIZE-1:0] id_pc
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    logic [CW-1:0] count, pending;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW:0]   used;
    logic          credit, rsp_drop, rsp_fill;

    // Slots held by killed-but-unanswered requests still count against credit.
    assign used           = {1'b0, count} + {1'b0, drop_q};
    assign credit         = used < DEPTH_L;
    assign imem_req_valid = rst_n & pc_valid & credit & ~flush;
    assign imem_req_addr  = pc_addr;
    assign pc_ready       = imem_req_valid & imem_req_ready;

    assign rsp_drop = imem_rsp_valid & (drop_q != '0);
    assign rsp_fill = imem_rsp_valid & (drop_q == '0) & (pending != '0);

    // A response landing in the flush cycle consumes one outstanding request.
    always_comb begin
        drop_d = drop_q;
        if (flush)         drop_d = drop_q + pending - CW'(rsp_drop | rsp_fill);
        else if (rsp_drop) drop_d = drop_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_q <= '0;
        else        drop_q <= drop_d;
    end

    fetch_queue #(
        .WORDSIZE (WORDSIZE),
        .IW       (INSTR_W),
        .DEPTH    (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (pc_ready),
        .push_pc_i    (pc_addr),
        .fill_i       (rsp_fill & ~flush),
        .fill_data_i  (imem_rsp_data),
        .pop_i        (id_valid & id_ready & ~flush),
        .flush_i      (flush),
        .count_o      (count),
        .pending_o    (pending),
        .head_valid_o (id_valid),
        .head_instr_o (id_instr),
        .head_pc_o    (id_pc)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised bench for instruction_fetch with a transaction-level reference model.
module tb_instruction_fetch;

    localparam int WS = 64, IW = 32, DEPTH = 2;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [WS-1:0] pc_addr, imem_req_addr, id_pc;
    logic          pc_valid, pc_ready, imem_req_valid, imem_req_ready;
    logic          imem_rsp_valid, flush, id_valid, id_ready;
    logic [IW-1:0] imem_rsp_data, id_instr;

    always #5 clk = ~clk;

    instruction_fetch #(.WORDSIZE(WS), .INSTR_W(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .flush(flush), .id_valid(id_valid),
        .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
    );

    int checks = 0, failures = 0;
    int cyc = 0, mem_lat = 1, last_due = 0, n_pop = 0;
    bit last_acc = 0;
    logic [WS-1:0] last_pop_pc = '0;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(logic [63:0] a);
        if (a == 64'h0) return 32'h0050_0093;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h13;
    endfunction

    // Memory: in-order, fixed latency per request, one response per cycle.
    typedef struct {logic [63:0] a; int due;} mr_t;
    mr_t mq[$];

    always @(negedge clk) begin
        int d;
        if (rst_n && imem_req_valid && imem_req_ready) begin
            d = cyc + mem_lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq.push_back('{imem_req_addr, d});
        end
    end

    always @(posedge clk) begin
        mr_t m;
        #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (!rst_n) begin
            mq.delete();
            last_due = cyc;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(m.a);
        end
    end

    // Reference model: requests in flight (live or killed) and instructions ready.
    typedef struct {logic [63:0] pc; bit live;} fl_t;
    typedef struct {logic [63:0] pc; logic [31:0] ins;} rd_t;
    fl_t infl[$];
    rd_t rdq[$];

    always @(negedge clk) begin
        fl_t f;
        rd_t r;
        bit  ev, epr, eiv;
        if (!rst_n) begin
            chk("rst_pc_ready", pc_ready, 0);
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_id_valid", id_valid, 0);
            chk("rst_id_instr", id_instr, 0);
            chk("rst_id_pc", id_pc, 0);
            infl.delete();
            rdq.delete();
            last_acc = 0;
        end else begin
            ev  = pc_valid && (infl.size() + rdq.size() < DEPTH) && !flush;
            epr = ev && imem_req_ready;
            eiv = rdq.size() > 0;
            chk("req_valid", imem_req_valid, ev);
            if (ev) chk("req_addr", imem_req_addr, pc_addr);
            chk("pc_ready", pc_ready, epr);
            chk("id_valid", id_valid, eiv);
            if (eiv) begin
                chk("id_pc", id_pc, rdq[0].pc);
                chk("id_instr", id_instr, rdq[0].ins);
            end else begin
                chk("idle_id_pc", id_pc, 0);
                chk("idle_id_instr", id_instr, 0);
            end
            last_acc = pc_ready;
            if (id_valid && id_ready && !flush) begin
                n_pop++;
                last_pop_pc = id_pc;
            end
            if (flush) begin
                if (imem_rsp_valid && infl.size() > 0) f = infl.pop_front();
                foreach (infl[k]) infl[k].live = 0;
                rdq.delete();
            end else begin
                if (eiv && id_ready) r = rdq.pop_front();
                if (imem_rsp_valid && infl.size() > 0) begin
                    f = infl.pop_front();
                    if (f.live) rdq.push_back('{f.pc, mem_data(f.pc)});
                end
                if (epr) infl.push_back('{pc_addr, 1'b1});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        pc_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic wait_acc(string name);
        bit ok = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (last_acc) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int acc, p0;
        pc_valid = 0; pc_addr = '0; imem_req_ready = 1; id_ready = 0; flush = 0;
        imem_rsp_valid = 0; imem_rsp_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // First fetch: response one cycle after the request, decode one after that
        pc_valid = 1; pc_addr = '0;
        step(); pc_valid = 0;
        step();
        @(negedge clk);
        chk("p1_id_valid", id_valid, 1);
        chk("p1_id_pc", id_pc, 0);
        chk("p1_id_instr", id_instr, 32'h0050_0093);
        step(); id_ready = 1;
        step(); id_ready = 0;
        idle(3);

        // Queue full with decode stalled: only DEPTH requests go out
        acc = 0; pc_addr = '0; pc_valid = 1;
        repeat (6) begin
            step();
            if (last_acc) begin acc++; pc_addr++; end
        end
        chk("p2_accepts_while_full", acc, 2);
        id_ready = 1; step(); id_ready = 0;
        @(negedge clk);
        chk("p2_accept_after_pop", pc_ready, 1);
        step(); pc_valid = 0;
        id_ready = 1; idle(6);

        // Streaming 0..7
        mem_lat = 1; p0 = n_pop; pc_addr = '0; pc_valid = 1; acc = 0;
        for (int i = 0; i < 100 && acc < 8; i++) begin
            step();
            if (last_acc) begin acc++; pc_addr++; end
            if (acc == 8) pc_valid = 0;
        end
        chk("p3_issued", acc, 8);
        idle(8);
        chk("p3_delivered", n_pop - p0, 8);
        chk("p3_last_pc", last_pop_pc, 7);

        // Two requests in flight, then flush; responses must be dropped
        mem_lat = 3; p0 = n_pop; pc_addr = 64'h10; pc_valid = 1;
        step(); chk("p4_req0", last_acc, 1); pc_addr = 64'h11;
        step(); chk("p4_req1", last_acc, 1); pc_valid = 0; flush = 1;
        step(); flush = 0;
        pc_addr = 64'h40; pc_valid = 1;
        wait_acc("p4_wait_0x40");
        pc_valid = 0; idle(10);
        chk("p4_delivered", n_pop - p0, 1);
        chk("p4_pc", last_pop_pc, 64'h40);

        // Flush in the same cycle as the response to a pending entry
        mem_lat = 2; id_ready = 0; p0 = n_pop; pc_addr = 64'h80; pc_valid = 1;
        step(); chk("p5_req0", last_acc, 1); pc_addr = 64'h84;
        step(); chk("p5_req1", last_acc, 1); pc_valid = 0; flush = 1;
        step(); flush = 0;
        idle(3);
        pc_addr = 64'h90; pc_valid = 1;
        wait_acc("p5_wait_0x90");
        pc_valid = 0; id_ready = 1; idle(8);
        chk("p5_delivered", n_pop - p0, 1);
        chk("p5_pc", last_pop_pc, 64'h90);

        // Asynchronous reset with a full queue
        mem_lat = 1; id_ready = 0; pc_addr = 64'h100; pc_valid = 1;
        repeat (6) begin
            step();
            if (last_acc) pc_addr = pc_addr + 4;
        end
        @(negedge clk);
        chk("p6_full_valid", id_valid, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("p6_async_id_valid", id_valid, 0);
        chk("p6_async_id_pc", id_pc, 0);
        chk("p6_async_id_instr", id_instr, 0);
        chk("p6_async_pc_ready", pc_ready, 0);
        chk("p6_async_req_valid", imem_req_valid, 0);
        step(); step();
        rst_n = 1'b1; pc_addr = 64'h200; pc_valid = 1;
        @(negedge clk);
        chk("p6_first_accept", pc_ready, 1);
        step(); pc_valid = 0; id_ready = 1;
        idle(5);
        chk("p6_pc", last_pop_pc, 64'h200);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            if (last_acc) pc_addr = pc_addr + 4;
            flush = ($urandom_range(0, 24) == 0);
            if (flush) pc_addr = {$urandom(), $urandom()};
            pc_valid       = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 2) != 0);
            mem_lat        = $urandom_range(1, 4);
        end
        flush = 0; imem_req_ready = 1; id_ready = 1;
        idle(20);
        @(negedge clk);
        chk("drain_empty", id_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
